// File: rtl/fifo_pkg.sv
// Shared constants and types for the 4-entry, 4-bit first-word-fall-through FIFO.
package fifo_pkg;

    localparam int FIFO_WIDTH = 4;
    localparam int FIFO_DEPTH = 4;
    // Two index bits plus one wrap bit, so full and empty stay distinguishable.
    localparam int PTR_W      = 3;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
    typedef logic [PTR_W-1:0]      fifo_ptr_t;

endpackage

// File: rtl/mux4_to_1.sv
// 4-bit wide 4:1 multiplexer built from AND/OR terms; selects i0..i3 by {s1,s0}.
import fifo_pkg::*;

module mux4_to_1 (
    input  logic [FIFO_WIDTH-1:0] i0,
    input  logic [FIFO_WIDTH-1:0] i1,
    input  logic [FIFO_WIDTH-1:0] i2,
    input  logic [FIFO_WIDTH-1:0] i3,
    input  logic                  s1,
    input  logic                  s0,
    output logic [FIFO_WIDTH-1:0] y
);

    logic sel0;
    logic sel1;
    logic sel2;
    logic sel3;

    // One-hot decode of the select lines.
    assign sel0 = ~s1 & ~s0;
    assign sel1 = ~s1 &  s0;
    assign sel2 =  s1 & ~s0;
    assign sel3 =  s1 &  s0;

    // Sum-of-products per bit: exactly one term is enabled at a time.
    assign y = (i0 & {FIFO_WIDTH{sel0}})
             | (i1 & {FIFO_WIDTH{sel1}})
             | (i2 & {FIFO_WIDTH{sel2}})
             | (i3 & {FIFO_WIDTH{sel3}});

endmodule

// File: rtl/fifo_4x4.sv
// Four-entry, 4-bit synchronous FIFO with first-word-fall-through read.
// Handshake: a write is accepted on an edge where wr_en=1 and full=0, and a
// read is accepted where rd_en=1 and empty=0; a request made while the FIFO
// cannot take it is dropped and reported by a one-cycle overflow/underflow
// pulse on the following cycle. dout is valid whenever empty=0.
import fifo_pkg::*;

module fifo_4x4 (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    fifo_word_t mem [FIFO_DEPTH];
    fifo_ptr_t  wr_ptr;
    fifo_ptr_t  rd_ptr;
    logic       wr_accept;
    logic       rd_accept;

    // Flags come straight from the pointers, so they move on the same edge.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[1:0] == rd_ptr[1:0]) && (wr_ptr[2] != rd_ptr[2]);
    assign count = wr_ptr - rd_ptr;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    // Pointers, storage and error pulses; reset clears everything and ignores requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem       <= '{default: '0};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                mem[wr_ptr[1:0]] <= din;
                wr_ptr           <= wr_ptr + 3'd1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    // Head entry selected by the read index; stale when empty.
    mux4_to_1 u_read_mux (
        .i0 (mem[0]),
        .i1 (mem[1]),
        .i2 (mem[2]),
        .i3 (mem[3]),
        .s1 (rd_ptr[1]),
        .s0 (rd_ptr[0]),
        .y  (dout)
    );

endmodule

// File: tb/tb_fifo_4x4.sv
// Directed bench for fifo_4x4: queue-based reference model, per-cycle compare
// process, and literal expectations along the stimulus sequence.
module tb_fifo_4x4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] din;
    logic       rd_en;
    logic [3:0] dout;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [3:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic       exp_udf = 1'b0;
    logic       model_ready = 1'b0;

    fifo_4x4 dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO behaviour as a plain queue with occupancy rules.
    always @(posedge clk) begin
        int sz;
        sz = exp_q.size();
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            model_ready = 1'b1;
        end else begin
            exp_ovf = wr_en && (sz == 4);
            exp_udf = rd_en && (sz == 0);
            if (rd_en && sz > 0) void'(exp_q.pop_front());
            if (wr_en && sz < 4) exp_q.push_back(din);
        end
    end

    // Compare process: every cycle after the first reset edge.
    always @(negedge clk) begin
        if (model_ready) begin
            int sz;
            sz = exp_q.size();
            chk("empty", {7'd0, empty}, {7'd0, sz == 0});
            chk("full", {7'd0, full}, {7'd0, sz == 4});
            chk("count", {5'd0, count}, sz[7:0]);
            chk("overflow", {7'd0, overflow}, {7'd0, exp_ovf});
            chk("underflow", {7'd0, underflow}, {7'd0, exp_udf});
            if (sz > 0) chk("dout_head", {4'd0, dout}, {4'd0, exp_q[0]});
        end
    end

    // Drive one cycle of inputs, then settle past the edge.
    task automatic step(input logic r, input logic we, input logic re, input logic [3:0] d);
        rst   = r;
        wr_en = we;
        rd_en = re;
        din   = d;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] wr_vals [4];

    initial begin
        wr_vals[0] = 4'hA;
        wr_vals[1] = 4'h3;
        wr_vals[2] = 4'h5;
        wr_vals[3] = 4'hC;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 4'h0;

        // Reset then idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_empty", {7'd0, empty}, 8'd1);
        chk("rst_full", {7'd0, full}, 8'd0);
        chk("rst_count", {5'd0, count}, 8'd0);
        chk("rst_dout", {4'd0, dout}, 8'h0);
        chk("rst_pulses", {6'd0, overflow, underflow}, 8'd0);

        // Fill with A,3,5,C
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, wr_vals[i]);
            chk("fill_count", {5'd0, count}, 8'(i + 1));
            chk("fill_dout", {4'd0, dout}, 8'hA);
        end
        chk("fill_full", {7'd0, full}, 8'd1);

        // Write while full
        step(0, 1, 0, 4'h7);
        chk("ovf_pulse", {7'd0, overflow}, 8'd1);
        chk("ovf_count", {5'd0, count}, 8'd4);
        step(0, 0, 0, 0);
        chk("ovf_clear", {7'd0, overflow}, 8'd0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain_dout", {4'd0, dout}, {4'd0, wr_vals[i]});
            step(0, 0, 1, 0);
        end
        chk("drain_empty", {7'd0, empty}, 8'd1);

        // Read while empty
        step(0, 0, 1, 0);
        chk("udf_pulse", {7'd0, underflow}, 8'd1);
        chk("udf_count", {5'd0, count}, 8'd0);
        step(0, 0, 0, 0);
        chk("udf_clear", {7'd0, underflow}, 8'd0);

        // Streaming with one entry held; pointers wrap
        step(0, 1, 0, 4'h1);
        chk("stream_first", {4'd0, dout}, 8'h1);
        for (int d = 2; d <= 11; d++) begin
            step(0, 1, 1, 4'(d));
            chk("stream_count", {5'd0, count}, 8'd1);
            chk("stream_dout", {4'd0, dout}, 8'(d));
        end

        // Empty with both requests: only the write lands
        step(0, 0, 1, 0);
        step(0, 1, 1, 4'hE);
        chk("both_empty_udf", {7'd0, underflow}, 8'd1);
        chk("both_empty_count", {5'd0, count}, 8'd1);
        chk("both_empty_dout", {4'd0, dout}, 8'hE);

        // Full with both requests: only the read lands
        step(0, 1, 0, 4'h6);
        step(0, 1, 0, 4'h9);
        step(0, 1, 0, 4'h4);
        chk("both_full_pre", {7'd0, full}, 8'd1);
        step(0, 1, 1, 4'hB);
        chk("both_full_ovf", {7'd0, overflow}, 8'd1);
        chk("both_full_count", {5'd0, count}, 8'd3);
        chk("both_full_dout", {4'd0, dout}, 8'h6);

        // Reset mid-operation with a write request
        step(1, 1, 0, 4'hF);
        chk("midrst_count", {5'd0, count}, 8'd0);
        chk("midrst_empty", {7'd0, empty}, 8'd1);
        chk("midrst_dout", {4'd0, dout}, 8'h0);
        step(0, 0, 0, 0);
        chk("midrst_discard", {5'd0, count}, 8'd0);
        step(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
